sample_mixer: RTL and testbench
===============================

# sample_mixer

Requester end of the note players' sample handshake. On each codec request the block broadcasts one `generate_next_sample` pulse to every note-player voice and captures each voice's `harmonic_ready`/`harmonic_out` pair. It then sums the captured samples into one signed 18-bit mixed sample and hands that sample to the codec with a one-cycle valid pulse. It sits between the note-player bank and the codec interface.

## Interface
- `NUM_VOICES`, 3: number of note-player voices (1–8).
- `SAMPLE_W`, 18: signed sample width of voices and of the mix output.
- `TIMEOUT`, 255: maximum number of cycles spent in COLLECT (≥2).

- `clk` in 1: system clock; everything is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `codec_req` in 1: single-cycle pulse; the codec wants one mixed sample.
- `voice_enable` in NUM_VOICES: per-voice participation mask.
- `voice_ready` in NUM_VOICES: per-voice sample-ready pulse (`harmonic_ready`).
- `voice_sample` in NUM_VOICES*SAMPLE_W: voice i occupies bits [i*SAMPLE_W +: SAMPLE_W], two's complement.
- `generate_next_sample` out 1: broadcast request pulse to all voices.
- `mix_out` out SAMPLE_W: mixed sample, held until the next update.
- `mix_valid` out 1: one-cycle pulse; `mix_out` is new.
- `timeout_err` out 1: pulses together with `mix_valid` when a voice failed to answer.
- `overrun` out 1: one-cycle pulse; a `codec_req` arrived while busy and was dropped.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, REQUEST, COLLECT, SUM.
- IDLE: if `codec_req` is high, go to REQUEST. Otherwise stay.
- REQUEST, 1 cycle:
  - `generate_next_sample` is high.
  - Latch `voice_enable` into `en_q`.
  - Clear all `captured` flags, all capture registers and the timeout counter.
  - Go to COLLECT.
- COLLECT, each cycle:
  - For every voice i with `en_q[i]` high, `captured[i]` low and `voice_ready[i]` high: store `voice_sample[i]` and set `captured[i]`.
  - Go to SUM when `(captured | ready_now | ~en_q)` is all ones.
  - Otherwise go to SUM when the counter equals TIMEOUT-1, and set the pending-timeout flag.
  - Otherwise increment the counter.
- SUM, 1 cycle:
  - Sign-extend the captured samples to SAMPLE_W+3 bits and add them. Disabled and missing voices contribute 0.
  - Register the result into `mix_out`.
  - Pulse `mix_valid`, and pulse `timeout_err` if the pending-timeout flag is set.
  - Return to IDLE.
- Ignored inputs:
  - A second `voice_ready` from an already captured voice (the first sample wins).
  - `voice_ready` outside COLLECT.
  - Changes to `voice_enable` after REQUEST.
- All voices disabled: the request is still broadcast; the block exits COLLECT after 1 cycle with `mix_out` = 0.
- `codec_req` while `busy`: the request is dropped, `overrun` pulses the next cycle, and the transaction in flight is unaffected.

## Timing
- Reset values (asynchronous, while `reset_n` = 0):
  - state IDLE;
  - `mix_out` = 0;
  - `mix_valid`, `timeout_err`, `overrun`, `generate_next_sample`, `busy` = 0;
  - all flags and counters = 0.
- Reset mid-transaction aborts the transaction; no `mix_valid` is produced for it.
- `codec_req` sampled at edge 0 → `generate_next_sample` high in cycle 1, exactly 1 cycle wide.
- Completion latency: last needed `voice_ready` in cycle k → SUM in cycle k+1 → `mix_valid` and the new `mix_out` visible in cycle k+2.
- Ready in the same cycle as REQUEST is not captured; voices must answer in COLLECT (note players answer ≥2 cycles after the request).
- Worst case, request to `mix_valid`: TIMEOUT + 3 cycles.
- Back-to-back: a `codec_req` in the IDLE cycle that shows `mix_valid` is accepted.

## Configuration
- `SAMPLE_MIXER_SATURATE_EN` defined: the wide sum is clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], i.e. [-131072, 131071] at 18 bits.
- Not defined: `mix_out` takes the low SAMPLE_W bits of the sum (two's-complement wrap), with no clamp logic.

## Test plan
- Basic mix: NUM_VOICES=3, all enabled, samples 1000 / -200 / 50 with readies 3 / 5 / 4 cycles after `generate_next_sample` → `mix_out`=850; `mix_valid` 2 cycles after the last ready; `timeout_err`=0.
- Overflow: samples 100000 / 100000 / 0 → with the macro, `mix_out`=131071; without it, `mix_out`=-62144.
- Mask: `voice_enable`=3'b101, voice 1 silent, samples 7 / x / -3 → `mix_out`=4; no timeout; voice 1 toggles `voice_enable` mid-COLLECT with no effect.
- Timeout: TIMEOUT=16, voice 2 never ready, samples 10 / 20 → `mix_valid` and `timeout_err` high together 18 cycles after the `generate_next_sample` cycle; `mix_out`=30.
- Overrun and duplicates: `codec_req` during COLLECT → `overrun` pulse, no second `generate_next_sample`; a repeated ready from voice 0 carrying 999 does not replace the first sample of 1.
- Reset: `reset_n` low during COLLECT → all outputs 0 immediately, no `mix_valid`; after release a fresh request completes normally.

Source files
------------

// File: rtl/sample_mixer.sv
// rtl/sample_mixer.sv - broadcasts a sample request to the note-player voices, collects their answers and hands the mix to the codec
// Optional output clamp: define SAMPLE_MIXER_SATURATE_EN.
module sample_mixer #(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = 18,
  parameter int TIMEOUT    = 255
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           codec_req,
  input  logic [NUM_VOICES-1:0]          voice_enable,
  input  logic [NUM_VOICES-1:0]          voice_ready,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic                           generate_next_sample,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_valid,
  output logic                           timeout_err,
  output logic                           overrun,
  output logic                           busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef SAMPLE_MIXER_SATURATE_EN
  localparam int SUM_W = SAMPLE_W + 3;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{4{1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{4{1'b1}}, {(SAMPLE_W-1){1'b0}}};
`else
  // Wrapping keeps only the low bits, and those do not depend on the guard bits.
  localparam int SUM_W = SAMPLE_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_COLLECT = 2'd2,
    S_SUM     = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [NUM_VOICES-1:0]   r_en_q;
  logic [NUM_VOICES-1:0]   r_captured;
  logic [SAMPLE_W-1:0]     r_cap [NUM_VOICES];
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_to_pend;
  logic [SAMPLE_W-1:0]     r_mix;
  logic                    r_mix_valid;
  logic                    r_timeout_err;
  logic                    r_overrun;

  logic [NUM_VOICES-1:0]   w_take;
  logic                    w_all_done;
  logic                    w_cnt_last;
  logic signed [SUM_W-1:0] w_sum;
  logic [SAMPLE_W-1:0]     w_mix;

  always_comb begin
    w_take     = r_en_q & ~r_captured & voice_ready;
    w_all_done = &(r_captured | voice_ready | ~r_en_q);
    w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_sum = w_sum + SUM_W'($signed(r_cap[i]));
    end
`ifdef SAMPLE_MIXER_SATURATE_EN
    if (w_sum > SAT_MAX) begin
      w_mix = SAT_MAX[SAMPLE_W-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_mix = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      w_mix = w_sum[SAMPLE_W-1:0];
    end
`else
    w_mix = w_sum[SAMPLE_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (codec_req) w_next = S_REQUEST;
      S_REQUEST: w_next = S_COLLECT;
      S_COLLECT: if (w_all_done || w_cnt_last) w_next = S_SUM;
      S_SUM:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en_q        <= '0;
      r_captured    <= '0;
      r_cnt         <= '0;
      r_to_pend     <= 1'b0;
      r_mix         <= '0;
      r_mix_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_cap[i] <= '0;
      end
    end else begin
      r_mix_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      // A request is only accepted from IDLE; anywhere else it is dropped and flagged.
      r_overrun     <= codec_req && (r_state != S_IDLE);
      case (r_state)
        S_REQUEST: begin
          r_en_q     <= voice_enable;
          r_captured <= '0;
          r_cnt      <= '0;
          r_to_pend  <= 1'b0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            r_cap[i] <= '0;
          end
        end
        S_COLLECT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_take[i]) begin
              r_cap[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
            end
          end
          r_captured <= r_captured | w_take;
          if (!w_all_done) begin
            if (w_cnt_last) begin
              r_to_pend <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_SUM: begin
          r_mix         <= w_mix;
          r_mix_valid   <= 1'b1;
          r_timeout_err <= r_to_pend;
        end
        default: begin
        end
      endcase
    end
  end

  assign generate_next_sample = (r_state == S_REQUEST);
  assign busy                 = (r_state != S_IDLE);
  assign mix_out              = r_mix;
  assign mix_valid            = r_mix_valid;
  assign timeout_err          = r_timeout_err;
  assign overrun              = r_overrun;

endmodule

// File: tb/tb_sample_mixer.sv
// tb/tb_sample_mixer.sv - self-checking bench for sample_mixer: directed table, reset abort, randomized transactions vs a reference model
module tb_sample_mixer;

  localparam int NV = 3;
  localparam int SW = 18;
  localparam int TO = 16;
`ifdef SAMPLE_MIXER_SATURATE_EN
  localparam int EXP_OVF = 131071;
  localparam int EXP_NEG = -131072;
`else
  localparam int EXP_OVF = -62144;
  localparam int EXP_NEG = 0;
`endif

  typedef struct {
    logic [2:0] en;
    int         s0, s1, s2;
    int         r0, r1, r2;
    int         dup_off, dup_val, req_off;
    logic [2:0] en_mid;
    logic       b2b;
    int         exp_mix;
    logic       exp_to;
    int         exp_lat;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             codec_req = 1'b0;
  logic [NV-1:0]    voice_enable = '0;
  logic [NV-1:0]    voice_ready = '0;
  logic [NV*SW-1:0] voice_sample = '0;
  logic             generate_next_sample;
  logic [SW-1:0]    mix_out;
  logic             mix_valid, timeout_err, overrun, busy;

  int errors = 0;
  int checks = 0;

  sample_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .codec_req(codec_req),
    .voice_enable(voice_enable), .voice_ready(voice_ready), .voice_sample(voice_sample),
    .generate_next_sample(generate_next_sample), .mix_out(mix_out), .mix_valid(mix_valid),
    .timeout_err(timeout_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every enabled voice must answer inside the TO-cycle window, else the mix closes at its end.
  function automatic vec_t model(input vec_t v);
    int s[3], r[3], sum, k;
    bit all;
    logic [17:0] lo;
    vec_t o = v;
    s = '{v.s0, v.s1, v.s2};
    r = '{v.r0, v.r1, v.r2};
    sum = 0; k = 1; all = 1;
    for (int i = 0; i < 3; i++) begin
      if (v.en[i]) begin
        if (r[i] >= 1 && r[i] <= TO) begin
          sum += s[i];
          if (r[i] > k) k = r[i];
        end else begin
          all = 0;
        end
      end
    end
    if (!all) k = TO;
`ifdef SAMPLE_MIXER_SATURATE_EN
    if (sum > 131071) sum = 131071;
    if (sum < -131072) sum = -131072;
    o.exp_mix = sum;
`else
    lo = sum[17:0];
    o.exp_mix = int'($signed(lo));
`endif
    o.exp_to  = !all;
    o.exp_lat = k + 2;
    return o;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int sv[3], rv[3];
    int ov_at, mv_at, extra_gns, busy_bad, mo, exp_ov;
    logic to;
    logic [NV*SW-1:0] vs;
    logic [NV-1:0] rdy;
    sv = '{v.s0, v.s1, v.s2};
    rv = '{v.r0, v.r1, v.r2};
    if (!codec_req) begin
      @(negedge clk);
      voice_enable = v.en;
      codec_req = 1'b1;
    end
    @(negedge clk);
    check($sformatf("v%0d_gns", id), {31'd0, generate_next_sample}, 1);
    check($sformatf("v%0d_busy_req", id), {31'd0, busy}, 1);
    codec_req = 1'b0;
    voice_enable = v.en;
    voice_ready = '0;
    ov_at = 0; mv_at = 0; extra_gns = 0; busy_bad = 0; mo = 0; to = 1'b0;
    for (int j = 1; j <= TO + 6 && mv_at == 0; j++) begin
      @(negedge clk);
      if (generate_next_sample) extra_gns++;
      if (overrun && ov_at == 0) ov_at = j;
      if (mix_valid) begin
        mv_at = j;
        mo = int'($signed(mix_out));
        to = timeout_err;
      end else begin
        if (!busy) busy_bad++;
        for (int i = 0; i < NV; i++) begin
          rdy[i] = (j == rv[i]);
          vs[i*SW +: SW] = rdy[i] ? SW'(sv[i]) : SW'($urandom);
        end
        if (v.dup_off != 0 && j == v.dup_off) begin
          rdy[0] = 1'b1;
          vs[0 +: SW] = SW'(v.dup_val);
        end
        voice_ready = rdy;
        voice_sample = vs;
        codec_req = (v.req_off != 0 && j == v.req_off);
        voice_enable = (j >= 2) ? v.en_mid : v.en;
      end
    end
    voice_ready = '0;
    codec_req = v.b2b;
    exp_ov = (v.req_off != 0) ? v.req_off + 1 : 0;
    check($sformatf("v%0d_latency", id), mv_at, v.exp_lat);
    check($sformatf("v%0d_mix_out", id), mo, v.exp_mix);
    check($sformatf("v%0d_timeout_err", id), {31'd0, to}, {31'd0, v.exp_to});
    check($sformatf("v%0d_overrun_at", id), ov_at, exp_ov);
    check($sformatf("v%0d_extra_gns", id), extra_gns, 0);
    check($sformatf("v%0d_busy_inflight", id), busy_bad, 0);
    if (!v.b2b) begin
      @(negedge clk);
      check($sformatf("v%0d_valid_width", id), {31'd0, mix_valid}, 0);
      check($sformatf("v%0d_idle", id), {31'd0, busy}, 0);
      check($sformatf("v%0d_hold", id), int'($signed(mix_out)), v.exp_mix);
    end
  endtask

  vec_t vecs[9];
  vec_t rv;

  initial begin
    vecs[0] = '{3'b111, 1000, -200, 50, 3, 5, 4, 0, 0, 0, 3'b111, 1'b0, 850, 1'b0, 7};
    vecs[1] = '{3'b111, 100000, 100000, 0, 2, 3, 4, 0, 0, 0, 3'b111, 1'b0, EXP_OVF, 1'b0, 6};
    vecs[2] = '{3'b101, 7, 12345, -3, 2, 3, 6, 0, 0, 0, 3'b111, 1'b0, 4, 1'b0, 8};
    vecs[3] = '{3'b111, 10, 20, 555, 4, 7, 0, 0, 0, 0, 3'b111, 1'b0, 30, 1'b1, 18};
    vecs[4] = '{3'b111, 1, 2, 3, 2, 4, 9, 5, 999, 3, 3'b111, 1'b0, 6, 1'b0, 11};
    vecs[5] = '{3'b000, 11, 22, 33, 2, 2, 2, 0, 0, 0, 3'b111, 1'b1, 0, 1'b0, 3};
    vecs[6] = '{3'b111, -131072, -131072, 0, 2, 2, 2, 0, 0, 0, 3'b111, 1'b0, EXP_NEG, 1'b0, 4};
    vecs[7] = '{3'b111, 5, 6, 7, 16, 3, 5, 0, 0, 0, 3'b111, 1'b0, 18, 1'b0, 18};
    vecs[8] = '{3'b111, 5, 6, 7, 17, 3, 5, 0, 0, 0, 3'b111, 1'b0, 13, 1'b1, 18};

    repeat (2) @(negedge clk);
    check("reset_ctrl_outputs",
          {27'd0, generate_next_sample, mix_valid, timeout_err, overrun, busy}, 0);
    check("reset_mix_out", int'(mix_out), 0);
    reset_n = 1'b1;

    for (int n = 0; n < 9; n++) run_vec(vecs[n], n);

    // Reset in the middle of COLLECT aborts the transaction.
    @(negedge clk);
    voice_enable = 3'b111;
    codec_req = 1'b1;
    @(negedge clk);
    codec_req = 1'b0;
    repeat (2) @(negedge clk);
    voice_ready = 3'b111;
    voice_sample = {18'sd3, 18'sd2, 18'sd1};
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ctrl_outputs",
          {27'd0, generate_next_sample, mix_valid, timeout_err, overrun, busy}, 0);
    check("midreset_mix_out", int'(mix_out), 0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midreset_no_valid%0d", c), {31'd0, mix_valid}, 0);
    end
    reset_n = 1'b1;
    voice_ready = '0;
    @(negedge clk);
    check("postreset_no_valid", {30'd0, mix_valid, busy}, 0);
    run_vec(vecs[0], 100);

    for (int n = 0; n < 30; n++) begin
      logic signed [17:0] t0, t1, t2;
      t0 = 18'($urandom); t1 = 18'($urandom); t2 = 18'($urandom);
      rv.en = 3'($urandom);
      rv.s0 = int'(t0); rv.s1 = int'(t1); rv.s2 = int'(t2);
      rv.r0 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TO + 2));
      rv.r1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TO + 2));
      rv.r2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TO + 2));
      rv.dup_off = (rv.r0 != 0 && $urandom_range(0, 1) == 1) ? rv.r0 + int'($urandom_range(1, 2)) : 0;
      rv.dup_val = int'(t1) ^ 5;
      rv.req_off = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
      rv.en_mid = 3'($urandom);
      rv.b2b = 1'($urandom);
      rv = model(rv);
      run_vec(rv, 200 + n);
    end
    if (codec_req) run_vec(vecs[0], 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
